image_frame_writer: RTL and testbench
=====================================

Name: image_frame_writer

Overview:
Write-side counterpart of the ROM reader path. It takes the processed pixel stream from the dilation, erosion and rotate stages and stores one complete frame into a single-port frame RAM. It generates raster addresses with valid/ready flow control and reports when the frame is complete. One clock domain; it sits between the processing stages and the output frame buffer.

Parameters:
DATA_WIDTH, 8, pixel width in bits
ADDR_WIDTH, 17, RAM address width
IMG_WIDTH, 145, pixels per line
IMG_HEIGHT, 145, lines per frame; IMG_WIDTH*IMG_HEIGHT must be ≤ 2^ADDR_WIDTH
BASE_ADDR, 0, RAM address of pixel (0,0)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse that arms a frame capture
pixel_in  in  DATA_WIDTH  processed pixel
pixel_valid  in  1  pixel_in is valid
pixel_ready  out  1  writer accepts the pixel this cycle
ram_ready  in  1  RAM accepts the current write
ram_we  out  1  write request
ram_addr  out  ADDR_WIDTH  write address
ram_data  out  DATA_WIDTH  write data
x_cnt  out  16  column of the next pixel to accept
y_cnt  out  16  line of the next pixel to accept
busy  out  1  capture in progress
frame_done  out  1  one-cycle pulse after the last write completes
err_start  out  1  sticky flag: start seen while busy

Behaviour:
- Reset (rst low, asynchronous): state IDLE. All outputs 0, including ram_we, ram_addr, ram_data, x_cnt, y_cnt, busy, frame_done and err_start. Any pending write is discarded.
- States: IDLE, WRITE, FLUSH, DONE.
- IDLE:
  - pixel_ready=0; input pixels are neither accepted nor counted.
  - start=1 → WRITE next cycle, with x_cnt=y_cnt=0, busy=1 and err_start cleared.
- WRITE:
  - pixel_ready = !ram_we || ram_ready. This is a one-deep output register.
  - A pixel is accepted when pixel_valid && pixel_ready.
  - Latency: a pixel accepted in cycle N appears in cycle N+1 as ram_we=1, ram_data=pixel, ram_addr=BASE_ADDR + y*IMG_WIDTH + x.
  - Addresses are computed incrementally (running address register, +1 per accept); no multiplier.
  - ram_we, ram_addr and ram_data hold stable until ram_ready=1. ram_we drops the cycle after acceptance unless a new pixel was accepted in the same cycle (back-to-back gives one write per cycle).
  - Counter advance: x_cnt increments; at IMG_WIDTH-1 it wraps to 0 and y_cnt increments.
  - Accepting pixel (IMG_WIDTH-1, IMG_HEIGHT-1) → FLUSH. pixel_ready=0 from then on.
- FLUSH: wait for ram_we && ram_ready on the last write → DONE.
- DONE: frame_done=1 for exactly one cycle, busy=0 → IDLE. x_cnt and y_cnt hold their final values until the next start.
- start while busy (WRITE, FLUSH, DONE): ignored, err_start←1 (sticky until the next accepted start).
- start in the same cycle as DONE's return to IDLE: ignored. start must come while in IDLE.
- pixel_valid while pixel_ready=0: the pixel is not consumed. The upstream must hold it.
- Address arithmetic is ADDR_WIDTH-bit unsigned with no wrap inside a legal frame. The parameter constraint guarantees this.

Decomposition:
- Shared package img_pkg:
  - DATA_WIDTH and IMG_WIDTH/IMG_HEIGHT defaults, shared with the cache and rotate blocks.
  - Writer state encoding constants: IDLE=2'd0, WRITE=2'd1, FLUSH=2'd2, DONE=2'd3.
- One sub-module, raster_counter: x/y counters, running address, last-pixel flag, with clear and advance inputs. It is reusable by the ROM read address generator.
- The output register and FSM stay in image_frame_writer.

Test Plan:
- Reset with IMG_WIDTH=4, IMG_HEIGHT=3; pulse start; hold pixel_valid=1, ram_ready=1, pixel_in = 0..11 → 12 writes on consecutive cycles at addresses 0..11 with data 0..11, first write one cycle after first accept; frame_done pulses once, 1 cycle after last write; busy falls with it.
- Same frame with ram_ready low on every other cycle → pixel_ready follows the stall; addresses and data unchanged; no pixel lost or duplicated; ram_addr/ram_data stable while ram_we=1 && ram_ready=0.
- BASE_ADDR=100, IMG_WIDTH=4: after accepting pixel 3 → x_cnt=0, y_cnt=1, next write address 104.
- pixel_valid=1 with no start → pixel_ready=0, no ram_we, counters stay 0; then start → first accepted pixel goes to BASE_ADDR.
- start pulsed mid-frame → err_start=1, frame continues unaffected; err_start clears on the next start accepted in IDLE.
- rst driven low while ram_we=1 in WRITE → all outputs 0 immediately (asynchronous); after release, state IDLE; a new start captures a full frame from address BASE_ADDR.

Source files
------------

// File: rtl/img_pkg.sv
// Shared image-pipeline definitions: default frame geometry, pixel width and
// the frame-writer state encoding.
package img_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int IMG_WIDTH  = 145;
  localparam int IMG_HEIGHT = 145;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } wr_state_e;

endpackage

// File: rtl/raster_counter.sv
// Raster position tracker: column/line counters plus a running linear address,
// cleared to (0,0)/BASE_ADDR and stepped once per advance. Shared with the ROM reader.
module raster_counter import img_pkg::*; #(
  parameter int          IMG_WIDTH  = img_pkg::IMG_WIDTH,
  parameter int          IMG_HEIGHT = img_pkg::IMG_HEIGHT,
  parameter int          ADDR_WIDTH = 17,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear_i,
  input  logic                  advance_i,
  output logic [15:0]           x_o,
  output logic [15:0]           y_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic                  last_o
);

  localparam logic [15:0]           X_MAX = 16'(IMG_WIDTH - 1);
  localparam logic [15:0]           Y_MAX = 16'(IMG_HEIGHT - 1);
  localparam logic [ADDR_WIDTH-1:0] BASE  = ADDR_WIDTH'(BASE_ADDR);

  logic [15:0]           x_q, x_d;
  logic [15:0]           y_q, y_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    x_d    = x_q;
    y_d    = y_q;
    addr_d = addr_q;
    if (clear_i) begin
      x_d    = '0;
      y_d    = '0;
      addr_d = BASE;
    end else if (advance_i) begin
      // Incremental address: raster order is linear, so no multiplier is needed.
      addr_d = addr_q + ADDR_WIDTH'(1);
      if (x_q == X_MAX) begin
        x_d = '0;
        y_d = y_q + 16'd1;
      end else begin
        x_d = x_q + 16'd1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q    <= '0;
      y_q    <= '0;
      addr_q <= BASE;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      addr_q <= addr_d;
    end
  end

  assign x_o    = x_q;
  assign y_o    = y_q;
  assign addr_o = addr_q;
  assign last_o = (x_q == X_MAX) && (y_q == Y_MAX);

endmodule

// File: rtl/image_frame_writer.sv
// Captures one raster frame from a valid/ready pixel stream into a single-port
// frame RAM through a one-deep write register, then pulses frame_done.
module image_frame_writer import img_pkg::*; #(
  parameter int          DATA_WIDTH = img_pkg::DATA_WIDTH,
  parameter int          ADDR_WIDTH = 17,
  parameter int          IMG_WIDTH  = img_pkg::IMG_WIDTH,
  parameter int          IMG_HEIGHT = img_pkg::IMG_HEIGHT,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] pixel_in,
  input  logic                  pixel_valid,
  output logic                  pixel_ready,
  input  logic                  ram_ready,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic [15:0]           x_cnt,
  output logic [15:0]           y_cnt,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  err_start
);

  wr_state_e             state_q, state_d;
  logic                  ram_we_q, ram_we_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0] ram_data_q, ram_data_d;
  logic                  err_q, err_d;

  logic                  accept;
  logic                  cnt_clear;
  logic [ADDR_WIDTH-1:0] cnt_addr;
  logic                  cnt_last;

  // A new pixel may enter whenever the output register is empty or draining now.
  assign pixel_ready = (state_q == WRITE) && (!ram_we_q || ram_ready);
  assign accept      = pixel_valid && pixel_ready;
  assign cnt_clear   = (state_q == IDLE) && start;

  raster_counter #(
    .IMG_WIDTH (IMG_WIDTH),
    .IMG_HEIGHT(IMG_HEIGHT),
    .ADDR_WIDTH(ADDR_WIDTH),
    .BASE_ADDR (BASE_ADDR)
  ) u_raster (
    .clk      (clk),
    .rst_n    (rst),
    .clear_i  (cnt_clear),
    .advance_i(accept),
    .x_o      (x_cnt),
    .y_o      (y_cnt),
    .addr_o   (cnt_addr),
    .last_o   (cnt_last)
  );

  always_comb begin
    state_d    = state_q;
    ram_we_d   = ram_we_q;
    ram_addr_d = ram_addr_q;
    ram_data_d = ram_data_q;
    err_d      = err_q;

    if (ram_we_q && ram_ready) ram_we_d = 1'b0;
    if (accept) begin
      ram_we_d   = 1'b1;
      ram_addr_d = cnt_addr;
      ram_data_d = pixel_in;
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = WRITE;
          err_d   = 1'b0;
        end
      end
      WRITE: begin
        if (start) err_d = 1'b1;
        if (accept && cnt_last) state_d = FLUSH;
      end
      FLUSH: begin
        if (start) err_d = 1'b1;
        if (ram_we_q && ram_ready) state_d = DONE;
      end
      DONE: begin
        // A start here lands on the way back to IDLE and is treated as an error.
        if (start) err_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      ram_we_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_data_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ram_we_q   <= ram_we_d;
      ram_addr_q <= ram_addr_d;
      ram_data_q <= ram_data_d;
      err_q      <= err_d;
    end
  end

  assign ram_we     = ram_we_q;
  assign ram_addr   = ram_addr_q;
  assign ram_data   = ram_data_q;
  assign err_start  = err_q;
  assign busy       = (state_q == WRITE) || (state_q == FLUSH);
  assign frame_done = (state_q == DONE);

endmodule

// File: tb/tb_image_frame_writer.sv
// Self-checking bench for image_frame_writer: randomized pixel/handshake traffic
// against a queue-based model of the expected RAM write stream.
module tb_image_frame_writer;

  localparam int DW   = 8;
  localparam int AW   = 17;
  localparam int W    = 4;
  localparam int H    = 3;
  localparam int BASE = 100;
  localparam int N    = W * H;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] pixel_in = '0;
  logic          pixel_valid = 1'b0;
  logic          ram_ready = 1'b0;
  logic          pixel_ready, ram_we, busy, frame_done, err_start;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data;
  logic [15:0]   x_cnt, y_cnt;

  always #5 clk = ~clk;

  image_frame_writer #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H),
    .BASE_ADDR (BASE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .pixel_in   (pixel_in),
    .pixel_valid(pixel_valid),
    .pixel_ready(pixel_ready),
    .ram_ready  (ram_ready),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_data   (ram_data),
    .x_cnt      (x_cnt),
    .y_cnt      (y_cnt),
    .busy       (busy),
    .frame_done (frame_done),
    .err_start  (err_start)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: a frame is "armed" from an accepted start until its
  // frame_done cycle; accepted pixels queue up as expected RAM writes.
  int            n_acc;
  int            wr_cnt;
  bit            armed;
  bit            done_pending;
  bit            done_now;
  bit            exp_err;
  int            q_addr[$];
  logic [DW-1:0] q_data[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    n_acc        = 0;
    wr_cnt       = 0;
    armed        = 1'b0;
    done_pending = 1'b0;
    done_now     = 1'b0;
    exp_err      = 1'b0;
    q_addr.delete();
    q_data.delete();
  endtask

  // One clock cycle: drive inputs, check at the falling edge, update the model.
  task automatic cycle(input bit st, input bit pv, input bit rr);
    bit writing;
    bit took;
    start       = st;
    pixel_valid = pv;
    ram_ready   = rr;
    @(negedge clk);
    done_now = armed && done_pending;
    writing  = armed && !done_pending && (n_acc < N);
    check("pixel_ready", 32'(pixel_ready), 32'(writing ? (!ram_we || rr) : 1'b0));
    check("ram_we", 32'(ram_we), 32'(q_addr.size() != 0));
    if (ram_we && q_addr.size() != 0) begin
      check("ram_addr", 32'(ram_addr), 32'(q_addr[0]));
      check("ram_data", 32'(ram_data), 32'(q_data[0]));
    end
    check("busy", 32'(busy), 32'(armed && !done_pending));
    check("frame_done", 32'(frame_done), 32'(done_now));
    check("err_start", 32'(err_start), 32'(exp_err));
    check("x_cnt", 32'(x_cnt), 32'(n_acc % W));
    check("y_cnt", 32'(y_cnt), 32'(n_acc / W));

    if (ram_we && rr && q_addr.size() != 0) begin
      void'(q_addr.pop_front());
      void'(q_data.pop_front());
      wr_cnt++;
      if (wr_cnt == N) done_pending = 1'b1;
    end
    took = pv && pixel_ready;
    if (took) begin
      q_addr.push_back(BASE + n_acc);
      q_data.push_back(pixel_in);
      n_acc++;
    end
    if (st) begin
      if (!armed) begin
        armed  = 1'b1;
        n_acc  = 0;
        wr_cnt = 0;
        exp_err = 1'b0;
      end else begin
        exp_err = 1'b1;
      end
    end
    if (done_now) begin
      armed        = 1'b0;
      done_pending = 1'b0;
    end
    @(posedge clk);
    #1;
    if (took) pixel_in = DW'($urandom);
  endtask

  // vmode: 0 valid always, 1 random. rmode: 0 ready always, 1 alternating, 2 random.
  task automatic run_frame(input int vmode, input int rmode, input int err_at,
                           input bit start_at_done, output int lat);
    bit fin;
    bit pv, rr, st;
    fin = 1'b0;
    lat = 0;
    cycle(1'b1, 1'b0, 1'b1);
    for (int k = 1; k < 400 && !fin; k++) begin
      pv = (vmode == 0) ? 1'b1 : (($urandom % 4) != 0);
      rr = (rmode == 0) ? 1'b1 : (rmode == 1) ? k[0] : (($urandom % 3) != 0);
      st = (k == err_at) || (start_at_done && armed && done_pending);
      cycle(st, pv, rr);
      if (done_now) begin
        fin = 1'b1;
        lat = k;
      end
    end
    if (!fin) check("frame_timeout", 32'(0), 32'(1));
  endtask

  int lat;

  initial begin
    model_reset();
    pixel_in = DW'($urandom);

    // Reset state
    #12;
    check("rst_ram_we", 32'(ram_we), 32'(0));
    check("rst_ram_addr", 32'(ram_addr), 32'(0));
    check("rst_ram_data", 32'(ram_data), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_pixel_ready", 32'(pixel_ready), 32'(0));
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Valid pixels with no start are ignored
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b1);

    // Full-throughput frame: done two cycles after the last accept
    run_frame(0, 0, 0, 1'b0, lat);
    check("frame_latency", 32'(lat), 32'(N + 2));
    cycle(1'b0, 1'b1, 1'b1);

    // RAM stalls every other cycle
    run_frame(0, 1, 0, 1'b0, lat);
    cycle(1'b0, 1'b0, 1'b1);

    // Random traffic with a start pulse mid-frame
    run_frame(1, 2, 5, 1'b0, lat);
    cycle(1'b0, 1'b1, 1'b0);

    // The next accepted start clears err_start; start during DONE is an error
    run_frame(1, 2, 0, 1'b1, lat);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b1);
    run_frame(0, 2, 0, 1'b0, lat);

    // Asynchronous reset while a write is stalled
    cycle(1'b1, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    check("pre_rst_ram_we", 32'(ram_we), 32'(1));
    #2;
    rst = 1'b0;
    #1;
    check("arst_ram_we", 32'(ram_we), 32'(0));
    check("arst_ram_addr", 32'(ram_addr), 32'(0));
    check("arst_ram_data", 32'(ram_data), 32'(0));
    check("arst_x_cnt", 32'(x_cnt), 32'(0));
    check("arst_busy", 32'(busy), 32'(0));
    model_reset();
    @(posedge clk);
    #1;
    cycle(1'b0, 1'b1, 1'b1);
    rst = 1'b1;
    cycle(1'b0, 1'b1, 1'b1);
    run_frame(1, 2, 0, 1'b0, lat);
    cycle(1'b0, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
